// File: rtl/data_mem_arbiter.sv
// Single-port data memory shared by a stall-free accelerator port and a CPU valid/ready port.
// The accelerator always wins; the CPU waits, and a sticky flag records prolonged starvation.
module data_mem_arbiter #(
   parameter int unsigned DATA_W       = 19,
   parameter int unsigned ADDR_W       = 19,
   parameter int unsigned DEPTH_LOG2   = 10,
   parameter int unsigned STARVE_LIMIT = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              acc_valid_i,
   input  logic              acc_write_i,
   input  logic [ADDR_W-1:0] acc_addr_i,
   input  logic [DATA_W-1:0] acc_wdata_i,
   output logic [DATA_W-1:0] acc_rdata_o,
   input  logic              cpu_valid_i,
   input  logic              cpu_write_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_ready_o,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              addr_err_o,
   output logic              cpu_starve_o
);

   localparam int unsigned Depth = 2 ** DEPTH_LOG2;
   localparam int unsigned CntW  = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {StIdle, StResp} state_e;

   logic [DATA_W-1:0]     mem_q [Depth];
   state_e                state_q;
   logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
   logic                  cpu_starve_q, cpu_starve_d;
   logic                  cpu_ready_q;
   logic [DATA_W-1:0]     cpu_rdata_q;
   logic                  addr_err_q;

   logic                  acc_in_range, cpu_in_range;
   logic [DEPTH_LOG2-1:0] acc_idx, cpu_idx;
   logic                  cpu_grant, acc_wr, cpu_wr;
   logic [DATA_W-1:0]     cpu_rd_data;

   assign acc_in_range = (acc_addr_i[ADDR_W-1:DEPTH_LOG2] == '0);
   assign cpu_in_range = (cpu_addr_i[ADDR_W-1:DEPTH_LOG2] == '0);
   assign acc_idx      = acc_addr_i[DEPTH_LOG2-1:0];
   assign cpu_idx      = cpu_addr_i[DEPTH_LOG2-1:0];

   // The CPU only touches the array in IDLE on a cycle the accelerator leaves free.
   assign cpu_grant   = (state_q == StIdle) && cpu_valid_i && !acc_valid_i;
   assign acc_wr      = acc_valid_i && acc_write_i && acc_in_range;
   assign cpu_wr      = cpu_grant && cpu_write_i && cpu_in_range;
   assign acc_rdata_o = acc_in_range ? mem_q[acc_idx] : '0;
   assign cpu_rd_data = cpu_in_range ? mem_q[cpu_idx] : '0;

   always_ff @(posedge clk_i) begin
      if (acc_wr) begin
         mem_q[acc_idx] <= acc_wdata_i;
      end else if (cpu_wr) begin
         mem_q[cpu_idx] <= cpu_wdata_i;
      end
   end

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == StIdle) begin
         if (cpu_valid_i && acc_valid_i) begin
            if (wait_cnt_q != CntW'(STARVE_LIMIT)) begin
               wait_cnt_d = wait_cnt_q + CntW'(1);
            end
         end else begin
            wait_cnt_d = '0;
         end
      end
      cpu_starve_d = cpu_starve_q || (wait_cnt_d == CntW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         wait_cnt_q   <= '0;
         cpu_starve_q <= 1'b0;
         cpu_ready_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         addr_err_q   <= 1'b0;
      end else begin
         wait_cnt_q   <= wait_cnt_d;
         cpu_starve_q <= cpu_starve_d;
         cpu_ready_q  <= cpu_grant;
         addr_err_q   <= (acc_valid_i && !acc_in_range) || (cpu_grant && !cpu_in_range);
         unique case (state_q)
            StIdle: begin
               if (cpu_grant) begin
                  state_q <= StResp;
                  if (!cpu_write_i) begin
                     cpu_rdata_q <= cpu_rd_data;
                  end
               end
            end
            StResp:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cpu_ready_o  = cpu_ready_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign addr_err_o   = addr_err_q;
   assign cpu_starve_o = cpu_starve_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter; CPU responses are checked against a queue of
// expectations pushed when each request is issued.
module tb_data_mem_arbiter;

   localparam int unsigned DATA_W       = 19;
   localparam int unsigned ADDR_W       = 19;
   localparam int unsigned DEPTH_LOG2   = 10;
   localparam int unsigned STARVE_LIMIT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              acc_valid, acc_write;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata, acc_rdata;
   logic              cpu_valid, cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
   logic              cpu_ready, addr_err, cpu_starve;

   typedef struct {
      logic [DATA_W-1:0] rdata;
      logic              err;
   } exp_t;

   exp_t              sb_q[$];
   logic [DATA_W-1:0] last_rd = '0;
   int                n_tests = 0;
   int                n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(
      .DATA_W       (DATA_W),
      .ADDR_W       (ADDR_W),
      .DEPTH_LOG2   (DEPTH_LOG2),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .acc_valid_i  (acc_valid),
      .acc_write_i  (acc_write),
      .acc_addr_i   (acc_addr),
      .acc_wdata_i  (acc_wdata),
      .acc_rdata_o  (acc_rdata),
      .cpu_valid_i  (cpu_valid),
      .cpu_write_i  (cpu_write),
      .cpu_addr_i   (cpu_addr),
      .cpu_wdata_i  (cpu_wdata),
      .cpu_ready_o  (cpu_ready),
      .cpu_rdata_o  (cpu_rdata),
      .addr_err_o   (addr_err),
      .cpu_starve_o (cpu_starve)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_issue(input logic w, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] exp_rd,
                            input logic exp_err);
      exp_t e;
      cpu_valid = 1'b1;
      cpu_write = w;
      cpu_addr  = a;
      cpu_wdata = d;
      if (!w) last_rd = exp_rd;
      e.rdata = last_rd;
      e.err   = exp_err;
      sb_q.push_back(e);
   endtask

   // Expects cpu_ready exactly one cycle after the cycle this is entered in.
   task automatic cpu_wait(input string tag);
      exp_t e;
      int   c;
      for (c = 0; c < 40; c++) begin
         @(negedge clk);
         if (cpu_ready === 1'b1) break;
      end
      check({tag, " latency"}, c, 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, " rdata"}, 32'(cpu_rdata), 32'(e.rdata));
         check({tag, " addr_err"}, 32'(addr_err), 32'(e.err));
      end
      tick;
      cpu_valid = 1'b0;
      @(negedge clk);
      check({tag, " ready pulse"}, 32'(cpu_ready), 0);
   endtask

   initial begin
      rst       = 1'b1;
      acc_valid = 1'b0;
      acc_write = 1'b0;
      acc_addr  = '0;
      acc_wdata = '0;
      cpu_valid = 1'b0;
      cpu_write = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      tick;
      tick;
      @(negedge clk);
      check("reset cpu_ready", 32'(cpu_ready), 0);
      check("reset cpu_rdata", 32'(cpu_rdata), 0);
      check("reset addr_err", 32'(addr_err), 0);
      check("reset cpu_starve", 32'(cpu_starve), 0);
      tick;
      rst = 1'b0;

      // Accelerator write then combinational read; same-cycle read sees old data.
      acc_valid = 1'b1;
      acc_write = 1'b1;
      acc_addr  = 19'd5;
      acc_wdata = 19'h12345;
      tick;
      acc_write = 1'b0;
      #1 check("acc rd addr5", 32'(acc_rdata), 32'h12345);
      tick;
      acc_write = 1'b1;
      acc_addr  = 19'd6;
      acc_wdata = 19'h2AAAA;
      tick;
      acc_wdata = 19'h15555;
      #1 check("acc old on write", 32'(acc_rdata), 32'h2AAAA);
      tick;
      acc_write = 1'b0;
      #1 check("acc rd addr6 new", 32'(acc_rdata), 32'h15555);
      acc_valid = 1'b0;
      @(negedge clk);
      check("acc in-range no err", 32'(addr_err), 0);

      // Uncontended CPU write then read.
      tick;
      cpu_issue(1'b1, 19'd9, 19'h00ABC, '0, 1'b0);
      cpu_wait("t2 wr");
      tick;
      cpu_issue(1'b0, 19'd9, '0, 19'h00ABC, 1'b0);
      cpu_wait("t2 rd");

      // Short contention: 3 accelerator cycles.
      tick;
      acc_valid = 1'b1;
      acc_addr  = 19'd5;
      cpu_issue(1'b0, 19'd5, '0, 19'h12345, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3 stalled", 32'(cpu_ready), 0);
         tick;
      end
      acc_valid = 1'b0;
      cpu_wait("t3 rd");
      check("t3 no starve", 32'(cpu_starve), 0);

      // Long contention: starvation flag after STARVE_LIMIT waits, sticky afterwards.
      tick;
      acc_valid = 1'b1;
      cpu_issue(1'b0, 19'd9, '0, 19'h00ABC, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 16) check("t4 starve before limit", 32'(cpu_starve), 0);
         if (i == 17) check("t4 starve at limit", 32'(cpu_starve), 1);
         if (i == 20) check("t4 stalled", 32'(cpu_ready), 0);
         tick;
      end
      acc_valid = 1'b0;
      cpu_wait("t4 rd");
      check("t4 starve sticky", 32'(cpu_starve), 1);

      // Out-of-range CPU accesses and the last in-range word.
      tick;
      cpu_issue(1'b1, 19'h00400, 19'h7FFFF, '0, 1'b1);
      cpu_wait("t5 oor wr");
      tick;
      cpu_issue(1'b0, 19'h00400, '0, '0, 1'b1);
      cpu_wait("t5 oor rd");
      tick;
      cpu_issue(1'b1, 19'h003FF, 19'h1F00F, '0, 1'b0);
      cpu_wait("t5 top wr");
      acc_addr = 19'h003FF;
      #1 check("t5 acc rd top", 32'(acc_rdata), 32'h1F00F);
      acc_addr = 19'h00400;
      #1 check("t5 acc rd oor", 32'(acc_rdata), 0);
      tick;
      acc_valid = 1'b1;
      acc_write = 1'b1;
      acc_addr  = 19'h00405;
      acc_wdata = 19'h7FFFF;
      tick;
      acc_valid = 1'b0;
      acc_write = 1'b0;
      @(negedge clk);
      check("t5 acc oor wr err", 32'(addr_err), 1);
      tick;
      @(negedge clk);
      check("t5 err one cycle", 32'(addr_err), 0);
      acc_addr = 19'd5;
      #1 check("t5 alias dropped", 32'(acc_rdata), 32'h12345);

      // Reset while a contended request would be granted.
      tick;
      acc_valid = 1'b1;
      acc_addr  = 19'd9;
      cpu_issue(1'b0, 19'd9, '0, 19'h00ABC, 1'b0);
      tick;
      rst       = 1'b1;
      acc_valid = 1'b0;
      tick;
      cpu_valid = 1'b0;
      @(negedge clk);
      check("t6 no ready", 32'(cpu_ready), 0);
      check("t6 rdata", 32'(cpu_rdata), 0);
      check("t6 addr_err", 32'(addr_err), 0);
      check("t6 starve", 32'(cpu_starve), 0);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      last_rd = '0;
      tick;
      rst = 1'b0;
      @(negedge clk);
      check("t6 still no ready", 32'(cpu_ready), 0);
      check("t6 mem kept", 32'(acc_rdata), 32'h00ABC);
      tick;
      cpu_issue(1'b0, 19'd9, '0, 19'h00ABC, 1'b0);
      cpu_wait("t6 rd");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
